burst_slot_table: RTL
=====================

# burst_slot_table

Parametrised write-burst slot table for the AXI write path. It accepts AW/W traffic and assembles each burst into one of `SLOT_AMOUNT` slots (header, byte data, byte strobes, status). Completion is announced by slot index; slots are read by index and freed by index in any order, which is what the speculative and divert logic downstream requires. It generalises the fixed-size `burst_slot` storage to configurable depth, bus width and burst length, and adds completion tracking and error flagging.

## Interface
- `SLOT_AMOUNT`, 8: number of slots; index width = `$clog2(SLOT_AMOUNT)`.
- `ID_WIDTH`, 4: AXI id width.
- `ADDR_WIDTH`, 32: address width.
- `DATA_BYTES`, 4: W bus width in bytes.
- `LEN_WIDTH`, 3: awlen width; max beats = 2**LEN_WIDTH.
- `USER_WIDTH`, 2: awuser (transaction type) width.
- Slot payload size: `DATA_BYTES*2**LEN_WIDTH` bytes.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `awvalid` in 1, `awready` out 1: AW handshake.
- `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awuser` in (param widths, 2, 2): AW fields.
- `wvalid` in 1, `wready` out 1, `wlast` in 1: W handshake and last beat.
- `wdata` in 8*DATA_BYTES: write data.
- `wstrb` in DATA_BYTES: write strobes.
- `done_valid` out 1: one-cycle pulse when a slot completes.
- `done_index` out IDX: index of the completed slot.
- `done_err` out 1: completed burst had a beat-count mismatch.
- `rd_index` in IDX: slot select for combinational read.
- `rd_slot` out struct: header, data, strb, err of the selected slot.
- `rd_valid` out 1: selected slot is complete.
- `rel_valid` in 1, `rel_index` in IDX: free a slot.
- `full` out 1: no free slot.
- `count` out IDX+1: number of occupied slots.

## Operation
- Slot states are FREE, FILL and DONE.
- **Allocation.** An AW handshake takes the lowest-index FREE slot. The slot latches the header, clears data and strb, sets the beat counter to 0 and enters FILL. Its index is pushed to the fill queue (depth `SLOT_AMOUNT`, in AW order).
- **Data fill.** W beats go to the head of the fill queue. For each beat:
  - Byte lane k is written at offset `beat*DATA_BYTES+k` only if `wstrb[k]`; the matching strb bit is set.
  - `awburst`=FIXED: offset uses beat=0.
  - INCR and WRAP: linear offset. WRAP is not address-wrapped.
- **Completion** occurs on whichever comes first:
  - `wlast`; or
  - the beat counter reaching `awlen` on an accepted beat.
  
  On completion the slot goes to DONE, pops from the fill queue and pulses `done_valid` with `done_index`.
  - `err` = (`wlast` arrived ≠ counter==`awlen`).
  - Once a slot completes early, the next beat goes to the next queued slot.
- **Release.** `rel_valid` on a DONE slot moves it to FREE. Release of a FREE or FILL slot is ignored.
- **Handshake readiness.**
  - `awready` = !full (see Configuration).
  - `wready` = fill queue non-empty.
- **Counting.** `count` +1 per allocation, −1 per effective release; both in the same cycle leave it unchanged.

## Timing
- **Reset values:**
  - All slots FREE, fill queue empty.
  - `awready`=1, `wready`=0, `done_valid`=0, `done_index`=0, `done_err`=0, `full`=0, `count`=0.
  - `rd_valid`=0, `rd_slot`=0.
- **AW to W:** a slot allocated at edge N is FILL after N. The earliest W beat for it is accepted in cycle N+1; there is no same-cycle AW→W bypass.
- **Completion latency:** `done_valid` is registered and asserts in the cycle after the final beat handshake.
- **Release timing:** a release at edge N makes the slot allocatable from cycle N+1. No same-cycle release→allocate bypass, so `full` stays 1 in the release cycle.
- **Read path:** `rd_slot` and `rd_valid` are combinational from the slot registers.
- **Reset mid-burst:** asynchronous reset drops all slots and the queue immediately. Any W beats still outstanding are not accepted (`wready`=0).

## Configuration
- Macro: `ID_BLOCK_EN`.
- **Defined:** `awready` is also deasserted while any non-FREE slot holds the same `awid`. This enforces one outstanding burst per id until release.
- **Undefined:** id reuse is unrestricted; only `full` throttles AW.

## Structure
- **Shared package (`pkg`):**
  - Tran-type constants REGULAR/BLOCK/DIVERT/UNLUCKY.
  - Burst-type constants FIXED=0, INCR=1, WRAP=2.
  - `slot_state_t` enum FREE/FILL/DONE.
  - Default parameter localparams.
- The slot struct depends on parameters and is declared as a typedef inside the module.
- **Sub-module:** `slot_alloc`, a parametrised lowest-free priority encoder that outputs index plus `any_free`.

## Test plan
- **Basic INCR burst:** AW id=3, awlen=3, INCR; 4 full-strobe beats 0x11111111..0x44444444 with `wlast` on beat 4 → `done_valid` with index 0 one cycle after beat 4, `err`=0. `rd_slot` data bytes 0–15 match and strb=16'hFFFF.
- **Fill to full, then release:** 8 AWs → `full`=1, `awready`=0, `count`=8. Release index 5 → next AW (cycle after the release) gets index 5.
- **Early `wlast`:** awlen=3 with `wlast` on beat 2 → slot done, `err`=1. The following beat fills the next queued slot at offset 0.
- **FIXED with partial strobes:** awlen=1, FIXED; beat1 strb=4'b0011 data 0xAAAAAAAA, beat2 strb=4'b1100 data 0xBBBBBBBB → bytes 0–3 = AA AA BB BB, strb=4'b1111.
- **`ID_BLOCK_EN` compiled in:** two AWs with id=7 → second stalls until the first slot is released, then is accepted.
- **Reset mid-fill:** reset asserted after 2 of 4 beats → immediately `count`=0, `wready`=0 and all slots FREE.

Source files
------------

// File: rtl/burst_slot_table_pkg.sv
// Shared constants and types for the write-burst slot table.
package burst_slot_table_pkg;

  // Transaction types carried on awuser.
  localparam logic [1:0] TRAN_REGULAR = 2'd0;
  localparam logic [1:0] TRAN_BLOCK   = 2'd1;
  localparam logic [1:0] TRAN_DIVERT  = 2'd2;
  localparam logic [1:0] TRAN_UNLUCKY = 2'd3;

  // AXI burst encodings.
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  // Lifecycle of one slot.
  typedef enum logic [1:0] {
    FREE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } slot_state_t;

  // Default geometry.
  localparam int DEF_SLOT_AMOUNT = 8;
  localparam int DEF_ID_WIDTH    = 4;
  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_DATA_BYTES  = 4;
  localparam int DEF_LEN_WIDTH   = 3;
  localparam int DEF_USER_WIDTH  = 2;

endpackage

// File: rtl/burst_slot_table_slot_alloc.sv
// Lowest-index-first priority encoder over a vector of free flags.
module slot_alloc #(
  parameter  int N     = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     free_vec,
  output logic [IDX_W-1:0] idx,
  output logic             any_free
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    idx      = '0;
    any_free = |free_vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/burst_slot_table.sv
// Write-burst slot table: assembles AW/W bursts into indexed slots that are
// read and released by index in any order.
// Optional macro ID_BLOCK_EN: stall AW while a live slot holds the same awid.
module burst_slot_table
  import burst_slot_table_pkg::*;
#(
  parameter  int SLOT_AMOUNT = DEF_SLOT_AMOUNT,
  parameter  int ID_WIDTH    = DEF_ID_WIDTH,
  parameter  int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter  int DATA_BYTES  = DEF_DATA_BYTES,
  parameter  int LEN_WIDTH   = DEF_LEN_WIDTH,
  parameter  int USER_WIDTH  = DEF_USER_WIDTH,
  localparam int IDX_W       = (SLOT_AMOUNT > 1) ? $clog2(SLOT_AMOUNT) : 1,
  localparam int PAY_BYTES   = DATA_BYTES * (2 ** LEN_WIDTH),
  localparam int HDR_W       = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 2 + 2 + USER_WIDTH,
  localparam int SLOT_W      = HDR_W + PAY_BYTES * 9 + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [LEN_WIDTH-1:0]    awlen,
  input  logic [1:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic [USER_WIDTH-1:0]   awuser,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic                    wlast,
  input  logic [8*DATA_BYTES-1:0] wdata,
  input  logic [DATA_BYTES-1:0]   wstrb,
  output logic                    done_valid,
  output logic [IDX_W-1:0]        done_index,
  output logic                    done_err,
  input  logic [IDX_W-1:0]        rd_index,
  output logic [SLOT_W-1:0]       rd_slot,
  output logic                    rd_valid,
  input  logic                    rel_valid,
  input  logic [IDX_W-1:0]        rel_index,
  output logic                    full,
  output logic [IDX_W:0]          count
);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [1:0]            size;
    logic [1:0]            burst;
    logic [USER_WIDTH-1:0] user;
  } hdr_t;

  // Packed so the read port is a flat vector: {hdr, data, strb, err}.
  typedef struct packed {
    hdr_t                   hdr;
    logic [PAY_BYTES*8-1:0] data;
    logic [PAY_BYTES-1:0]   strb;
    logic                   err;
  } slot_t;

  slot_t                slot_q  [SLOT_AMOUNT];
  slot_t                slot_d  [SLOT_AMOUNT];
  slot_state_t          state_q [SLOT_AMOUNT];
  slot_state_t          state_d [SLOT_AMOUNT];
  logic [LEN_WIDTH-1:0] beat_q  [SLOT_AMOUNT];
  logic [LEN_WIDTH-1:0] beat_d  [SLOT_AMOUNT];

  // Fill queue: slot indices in AW order awaiting W data.
  logic [IDX_W-1:0] fq_q [SLOT_AMOUNT];
  logic [IDX_W-1:0] fq_d [SLOT_AMOUNT];
  logic [IDX_W-1:0] fq_rd_q, fq_rd_d;
  logic [IDX_W-1:0] fq_wr_q, fq_wr_d;
  logic [IDX_W:0]   fq_cnt_q, fq_cnt_d;

  logic [IDX_W:0]   count_q, count_d;
  logic             done_valid_q, done_valid_d;
  logic [IDX_W-1:0] done_index_q, done_index_d;
  logic             done_err_q, done_err_d;

  logic [SLOT_AMOUNT-1:0] free_vec;
  logic [IDX_W-1:0]       alloc_idx;
  logic                   any_free;
  logic                   aw_fire;
  logic                   w_fire;
  logic                   rel_eff;
  logic [IDX_W-1:0]       head;

  for (genvar gi = 0; gi < SLOT_AMOUNT; gi++) begin : g_free
    assign free_vec[gi] = (state_q[gi] == FREE);
  end

  slot_alloc #(.N(SLOT_AMOUNT)) u_alloc (
    .free_vec (free_vec),
    .idx      (alloc_idx),
    .any_free (any_free)
  );

`ifdef ID_BLOCK_EN
  logic [SLOT_AMOUNT-1:0] id_hit_vec;
  for (genvar gi = 0; gi < SLOT_AMOUNT; gi++) begin : g_id_hit
    assign id_hit_vec[gi] = (state_q[gi] != FREE) && (slot_q[gi].hdr.id == awid);
  end
  assign awready = any_free && !(|id_hit_vec);
`else
  assign awready = any_free;
`endif

  assign full    = !any_free;
  assign wready  = (fq_cnt_q != '0);
  assign head    = fq_q[fq_rd_q];
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign rel_eff = rel_valid && (int'(rel_index) < SLOT_AMOUNT) && (state_q[rel_index] == DONE);

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    if (int'(p) == SLOT_AMOUNT - 1) return '0;
    return p + 1'b1;
  endfunction

  // Next-state: allocation, beat write/completion, release, queue and count.
  always_comb begin : p_next
    slot_t                cur;
    logic [LEN_WIDTH-1:0] beat;
    logic                 last_hit;
    int                   base;

    slot_d       = slot_q;
    state_d      = state_q;
    beat_d       = beat_q;
    fq_d         = fq_q;
    fq_rd_d      = fq_rd_q;
    fq_wr_d      = fq_wr_q;
    done_valid_d = 1'b0;
    done_index_d = done_index_q;
    done_err_d   = done_err_q;
    cur          = slot_q[head];
    beat         = beat_q[head];
    last_hit     = 1'b0;
    base         = 0;

    if (w_fire) begin
      // FIXED bursts overwrite the first beat position; INCR/WRAP are linear.
      base     = (cur.hdr.burst == BURST_FIXED) ? 0 : int'(beat) * DATA_BYTES;
      for (int k = 0; k < DATA_BYTES; k++) begin
        if (wstrb[k]) begin
          cur.data[(base + k) * 8 +: 8] = wdata[k * 8 +: 8];
          cur.strb[base + k]            = 1'b1;
        end
      end
      last_hit = (beat == cur.hdr.len);
      if (wlast || last_hit) begin
        cur.err       = (wlast != last_hit);
        state_d[head] = DONE;
        fq_rd_d       = ptr_inc(fq_rd_q);
        done_valid_d  = 1'b1;
        done_index_d  = head;
        done_err_d    = (wlast != last_hit);
      end else begin
        beat_d[head] = beat + 1'b1;
      end
      slot_d[head] = cur;
    end

    if (aw_fire) begin
      slot_d[alloc_idx].hdr.id    = awid;
      slot_d[alloc_idx].hdr.addr  = awaddr;
      slot_d[alloc_idx].hdr.len   = awlen;
      slot_d[alloc_idx].hdr.size  = awsize;
      slot_d[alloc_idx].hdr.burst = awburst;
      slot_d[alloc_idx].hdr.user  = awuser;
      slot_d[alloc_idx].data      = '0;
      slot_d[alloc_idx].strb      = '0;
      slot_d[alloc_idx].err       = 1'b0;
      beat_d[alloc_idx]           = '0;
      state_d[alloc_idx]          = FILL;
      fq_d[fq_wr_q]               = alloc_idx;
      fq_wr_d                     = ptr_inc(fq_wr_q);
    end

    if (rel_eff) state_d[rel_index] = FREE;

    fq_cnt_d = fq_cnt_q + (IDX_W + 1)'(aw_fire) - (IDX_W + 1)'(w_fire && (wlast || last_hit));
    count_d  = count_q + (IDX_W + 1)'(aw_fire) - (IDX_W + 1)'(rel_eff);
  end

  // State registers; reset clears every slot and the fill queue at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOT_AMOUNT; i++) begin
        slot_q[i]  <= '0;
        state_q[i] <= FREE;
        beat_q[i]  <= '0;
        fq_q[i]    <= '0;
      end
      fq_rd_q      <= '0;
      fq_wr_q      <= '0;
      fq_cnt_q     <= '0;
      count_q      <= '0;
      done_valid_q <= 1'b0;
      done_index_q <= '0;
      done_err_q   <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      state_q      <= state_d;
      beat_q       <= beat_d;
      fq_q         <= fq_d;
      fq_rd_q      <= fq_rd_d;
      fq_wr_q      <= fq_wr_d;
      fq_cnt_q     <= fq_cnt_d;
      count_q      <= count_d;
      done_valid_q <= done_valid_d;
      done_index_q <= done_index_d;
      done_err_q   <= done_err_d;
    end
  end

  // Combinational read of the selected slot.
  always_comb begin
    rd_slot  = '0;
    rd_valid = 1'b0;
    if (int'(rd_index) < SLOT_AMOUNT) begin
      rd_slot  = slot_q[rd_index];
      rd_valid = (state_q[rd_index] == DONE);
    end
  end

  assign done_valid = done_valid_q;
  assign done_index = done_index_q;
  assign done_err   = done_err_q;
  assign count      = count_q;

endmodule
